// File: rtl/weighted_sum_pipeline_n_if.sv
// weighted_sum_pipeline_n_if
// Sample, weight-load, accumulate-control and result signals of the
// weighted-sum pipeline. The pipeline connects through the slave modport;
// the sample source, weight loader and result sink use the master modport.
interface weighted_sum_pipeline_n_if #(
    parameter int N_TAPS   = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int OUT_W    = 16
) ();
    logic                        in_valid;
    logic                        in_ready;
    logic [N_TAPS*DATA_W-1:0]    in_data;
    logic                        w_we;
    logic [$clog2(N_TAPS)-1:0]   w_idx;
    logic [WEIGHT_W-1:0]         w_data;
    logic                        acc_en;
    logic                        acc_clr;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_W-1:0]            out_result;
    logic                        out_sat;

    modport master (
        output in_valid, in_data, w_we, w_idx, w_data, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, out_result, out_sat
    );

    modport slave (
        input  in_valid, in_data, w_we, w_idx, w_data, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, out_result, out_sat
    );
endinterface

// File: rtl/weighted_sum_pipeline_n.sv
// weighted_sum_pipeline_n
// Pipelined unsigned weighted sum over N_TAPS lanes with run-time weights,
// valid/ready flow control and an optional running total.
// Pipeline: lane products -> $clog2(N_TAPS) adder-tree levels -> accumulate/output
// register, i.e. 2+$clog2(N_TAPS) cycles from accept to out_valid.
// The whole pipe advances together; when the sink stalls, every stage holds.
// Build option: define WSUM_SATURATE_EN to clip out_result at 2^OUT_W-1 and
// flag clipped results on out_sat; without it out_result wraps and out_sat is 0.
module weighted_sum_pipeline_n #(
    parameter int N_TAPS   = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int OUT_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    weighted_sum_pipeline_n_if.slave  bus
);
    localparam int LVLS  = $clog2(N_TAPS);
    localparam int FW    = DATA_W + WEIGHT_W + LVLS;
    localparam int ACC_W = FW + OUT_W;

    logic [WEIGHT_W-1:0] weight [N_TAPS];
    // Heap-ordered tree: leaves N_TAPS..2*N_TAPS-1 hold lane products,
    // node i holds node[2i]+node[2i+1]; node 1 is the full sum.
    logic [FW-1:0]       node [1:2*N_TAPS-1];
    logic [LVLS:0]       stage_valid;
    logic                out_valid_r;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_base;
    logic [ACC_W-1:0]    acc_next;
    logic [OUT_W-1:0]    result;
    logic [OUT_W-1:0]    result_next;
    logic                advance;
    logic                enter_final;

    assign advance        = !out_valid_r || bus.out_ready;
    assign enter_final    = advance && stage_valid[LVLS];
    assign bus.in_ready   = advance;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = result;

    // Weight register file; writes land at the edge whether or not the pipe is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) weight[i] <= '0;
        end else if (bus.w_we) begin
            weight[bus.w_idx] <= bus.w_data;
        end
    end

    // Lane products and adder tree; each tree level is one pipeline stage.
    always_ff @(posedge clock) begin
        if (advance) begin
            for (int i = 0; i < N_TAPS; i++)
                node[N_TAPS+i] <= FW'(bus.in_data[i*DATA_W +: DATA_W]) * FW'(weight[i]);
            for (int i = 1; i < N_TAPS; i++)
                node[i] <= node[2*i] + node[2*i+1];
        end
    end

    // Valid bits travel with the data; reset drops anything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid <= '0;
            out_valid_r <= 1'b0;
        end else if (advance) begin
            stage_valid <= {stage_valid[LVLS-1:0], bus.in_valid};
            out_valid_r <= stage_valid[LVLS];
        end
    end

    // Next running total: a coincident clear is applied before the add.
    always_comb begin
        acc_base = bus.acc_clr ? '0 : acc;
        acc_next = ACC_W'(node[1]);
        if (bus.acc_en) acc_next = acc_base + ACC_W'(node[1]);
    end

`ifdef WSUM_SATURATE_EN
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'({OUT_W{1'b1}});
    logic clip;
    logic sat_r;
    assign clip         = acc_next > OUT_MAX;
    assign result_next  = clip ? '1 : acc_next[OUT_W-1:0];
    assign bus.out_sat  = sat_r;

    // Clip flag belongs to the result it is presented with.
    always_ff @(posedge clock) begin
        if (reset)            sat_r <= 1'b0;
        else if (enter_final) sat_r <= clip;
    end
`else
    assign result_next  = acc_next[OUT_W-1:0];
    assign bus.out_sat  = 1'b0;
`endif

    // Accumulator and output register; a lone clear leaves the presented result untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            result <= '0;
        end else if (enter_final) begin
            acc    <= acc_next;
            result <= result_next;
        end else if (bus.acc_clr) begin
            acc    <= '0;
        end
    end
endmodule

// File: tb/tb_weighted_sum_pipeline_n.sv
// tb_weighted_sum_pipeline_n
// Randomised and directed stimulus against a plain-arithmetic reference model
// of the weighted sum / running total. Expected results are queued in accept
// order and popped as the DUT delivers results.
module tb_weighted_sum_pipeline_n;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int OW    = 16;
    localparam int LV    = $clog2(N);
    localparam int FW    = DW + WW + LV;
    localparam int ACC_W = FW + OW;

    typedef struct packed {
        logic [OW-1:0] res;
        logic          sat;
    } exp_t;

    typedef struct packed {
        logic          fi;
        logic          fo;
        logic          ov;
        logic          ir;
        logic [OW-1:0] res;
        logic          sat;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [WW-1:0]    m_w [N];
    logic [ACC_W-1:0] m_acc;
    exp_t             exp_q [$];

    always #5 clk = ~clk;

    weighted_sum_pipeline_n_if #(.N_TAPS(N), .DATA_W(DW), .WEIGHT_W(WW), .OUT_W(OW)) bus ();

    weighted_sum_pipeline_n #(.N_TAPS(N), .DATA_W(DW), .WEIGHT_W(WW), .OUT_W(OW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    function automatic logic [N*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [N*DW-1:0] v;
        v = '0;
        v[0*DW +: DW] = DW'(a);
        v[1*DW +: DW] = DW'(b);
        v[2*DW +: DW] = DW'(c);
        v[3*DW +: DW] = DW'(d);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Reference: sum of lane*weight, then running total or plain sum, then output formatting.
    function automatic exp_t model_result(input logic [N*DW-1:0] d, input logic en);
        logic [ACC_W-1:0] s;
        exp_t e;
        s = '0;
        for (int i = 0; i < N; i++) s = s + ACC_W'(d[i*DW +: DW]) * ACC_W'(m_w[i]);
        m_acc = en ? m_acc + s : s;
`ifdef WSUM_SATURATE_EN
        e.sat = (m_acc >= (ACC_W'(1) << OW));
        e.res = e.sat ? '1 : m_acc[OW-1:0];
`else
        e.sat = 1'b0;
        e.res = m_acc[OW-1:0];
`endif
        return e;
    endfunction

    // One clock: observe handshakes just before the edge, update the model, advance to next negedge.
    task automatic tick(output obs_t o);
        #1;
        o.fi  = bus.in_valid && bus.in_ready && !rst;
        o.fo  = bus.out_valid && bus.out_ready && !rst;
        o.ov  = bus.out_valid;
        o.ir  = bus.in_ready;
        o.res = bus.out_result;
        o.sat = bus.out_sat;
        if (o.fi) exp_q.push_back(model_result(bus.in_data, bus.acc_en));
        if (bus.w_we && !rst) m_w[bus.w_idx] = bus.w_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_weights(input int w0, input int w1, input int w2, input int w3);
        obs_t o;
        int   w [N];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < N; i++) begin
            bus.w_we   = 1'b1;
            bus.w_idx  = LV'(i);
            bus.w_data = WW'(w[i]);
            tick(o);
        end
        bus.w_we = 1'b0;
    endtask

    task automatic clear_idle();
        obs_t o;
        bus.acc_clr = 1'b1;
        tick(o);
        bus.acc_clr = 1'b0;
        m_acc = '0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc = '0;
        for (int i = 0; i < N; i++) m_w[i] = '0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        tick(o);
        tick(o);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b, expected 0", bus.out_valid); end
        n_cmp++;
        if (bus.out_result !== '0) begin n_bad++; $display("FAIL reset_out_result: got %0d, expected 0", bus.out_result); end
        n_cmp++;
        if (bus.out_sat !== 1'b0) begin n_bad++; $display("FAIL reset_out_sat: got %0b, expected 0", bus.out_sat); end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b, expected 1", bus.in_ready); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_basic();
        obs_t o;
        exp_t e;
        int   acc_t;
        int   out_t;
        load_weights(8, 3, 6, 2);
        bus.acc_en    = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_data   = pack4(3, 1, 3, 2);
        acc_t = -1;
        out_t = -1;
        for (int t = 0; t < 20 && (acc_t < 0 || exp_q.size() > 0); t++) begin
            bus.in_valid = (acc_t < 0);
            tick(o);
            if (o.fi) acc_t = t;
            if (o.fo) begin
                out_t = t;
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL basic_result: got %0d, no result expected", o.res); end
                else begin
                    e = exp_q.pop_front();
                    if (o.res !== e.res || o.sat !== e.sat) begin
                        n_bad++; $display("FAIL basic_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (out_t - acc_t != 2 + LV) begin
            n_bad++; $display("FAIL basic_latency: got %0d cycles, expected %0d", out_t - acc_t, 2 + LV);
        end
    endtask

    task automatic test_accumulate();
        obs_t o;
        exp_t e;
        int   sent;
        int   acc_t;
        bus.acc_en  = 1'b1;
        clear_idle();
        bus.in_data = pack4(3, 1, 3, 2);
        sent = 0;
        for (int t = 0; t < 60 && (sent < 6 || exp_q.size() > 0); t++) begin
            bus.in_valid = (sent < 6);
            tick(o);
            if (o.fi) sent++;
            if (o.fo) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL acc_result: got %0d, no result expected", o.res); end
                else begin
                    e = exp_q.pop_front();
                    if (o.res !== e.res || o.sat !== e.sat) begin
                        n_bad++; $display("FAIL acc_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (sent != 6 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL acc_drain: sent %0d, %0d results outstanding, expected 6 sent and 0 outstanding", sent, exp_q.size());
        end
        // Clear timed to coincide with the first result entering the output stage.
        m_acc = '0;
        sent  = 0;
        acc_t = -1;
        for (int t = 0; t < 30 && (sent < 2 || exp_q.size() > 0); t++) begin
            bus.in_valid = (sent < 2);
            bus.acc_clr  = (acc_t >= 0 && t == acc_t + 3);
            tick(o);
            if (o.fi) begin
                if (sent == 0) acc_t = t;
                sent++;
            end
            if (o.fo) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL acc_clr_result: got %0d, no result expected", o.res); end
                else begin
                    e = exp_q.pop_front();
                    if (o.res !== e.res || o.sat !== e.sat) begin
                        n_bad++; $display("FAIL acc_clr_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.acc_en   = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL acc_clr_drain: %0d results outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_weight_timing();
        obs_t o;
        exp_t e;
        int   sent;
        load_weights(8, 3, 6, 2);
        bus.in_data = pack4(3, 1, 3, 2);
        sent = 0;
        for (int t = 0; t < 30 && (sent < 2 || exp_q.size() > 0); t++) begin
            bus.in_valid = (sent < 2);
            bus.w_we     = (sent == 0);
            bus.w_idx    = '0;
            bus.w_data   = WW'(1);
            tick(o);
            if (o.fi) sent++;
            if (o.fo) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL wtime_result: got %0d, no result expected", o.res); end
                else begin
                    e = exp_q.pop_front();
                    if (o.res !== e.res || o.sat !== e.sat) begin
                        n_bad++; $display("FAIL wtime_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.w_we     = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL wtime_drain: %0d results outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        obs_t          o;
        exp_t          e;
        int            sent;
        logic          prev_hold;
        logic [OW-1:0] prev_res;
        sent      = 0;
        prev_hold = 1'b0;
        prev_res  = '0;
        bus.in_data = rand_data();
        for (int t = 0; t < 80 && (sent < 12 || exp_q.size() > 0); t++) begin
            bus.out_ready = !(t >= 6 && t < 11);
            bus.in_valid  = (sent < 12);
            tick(o);
            if (prev_hold) begin
                n_cmp++;
                if (o.ov !== 1'b1 || o.res !== prev_res) begin
                    n_bad++; $display("FAIL bp_hold: got valid %0b result %0d, expected valid 1 result %0d", o.ov, o.res, prev_res);
                end
            end
            if (o.ov && !bus.out_ready) begin
                n_cmp++;
                if (o.ir !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %0b while stalled, expected 0", o.ir); end
            end
            prev_hold = o.ov && !bus.out_ready;
            prev_res  = o.res;
            if (o.fi) begin
                sent++;
                bus.in_data = rand_data();
            end
            if (o.fo) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_result: got %0d, no result expected", o.res); end
                else begin
                    e = exp_q.pop_front();
                    if (o.res !== e.res || o.sat !== e.sat) begin
                        n_bad++; $display("FAIL bp_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                    end
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (sent != 12 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL bp_drain: sent %0d, %0d outstanding, expected 12 sent and 0 outstanding", sent, exp_q.size());
        end
    endtask

    task automatic test_saturate();
        obs_t o;
        exp_t e;
        int   sent;
        logic [N*DW-1:0] d [2];
        load_weights(255, 255, 255, 255);
        d[0] = pack4(255, 255, 255, 255);
        d[1] = pack4(255, 255, 0, 0);
        sent = 0;
        for (int t = 0; t < 30 && (sent < 2 || exp_q.size() > 0); t++) begin
            bus.in_valid = (sent < 2);
            bus.in_data  = d[sent % 2];
            tick(o);
            if (o.fi) sent++;
            if (o.fo) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL sat_result: got %0d, no result expected", o.res); end
                else begin
                    e = exp_q.pop_front();
                    if (o.res !== e.res || o.sat !== e.sat) begin
                        n_bad++; $display("FAIL sat_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL sat_drain: %0d results outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        for (int seg = 0; seg < 2; seg++) begin
            bus.acc_en = (seg == 0);
            clear_idle();
            bus.in_data = rand_data();
            for (int t = 0; t < 300 && (t < 250 || exp_q.size() > 0); t++) begin
                bus.in_valid  = (t < 250) && ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 9) < 7);
                bus.w_we      = ($urandom_range(0, 4) == 0);
                bus.w_idx     = LV'($urandom);
                bus.w_data    = WW'($urandom);
                tick(o);
                if (o.fi || !bus.in_valid) bus.in_data = rand_data();
                if (o.fo) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin n_bad++; $display("FAIL rand_result: got %0d, no result expected", o.res); end
                    else begin
                        e = exp_q.pop_front();
                        if (o.res !== e.res || o.sat !== e.sat) begin
                            n_bad++; $display("FAIL rand_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                        end
                    end
                end
            end
            bus.in_valid  = 1'b0;
            bus.w_we      = 1'b0;
            bus.out_ready = 1'b1;
            n_cmp++;
            if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_drain: %0d results outstanding, expected 0", exp_q.size()); end
            exp_q.delete();
        end
        bus.acc_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        obs_t o;
        exp_t e;
        int   sent;
        load_weights(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)),
                     int'($urandom_range(1, 255)), int'($urandom_range(1, 255)));
        sent = 0;
        for (int t = 0; t < 10 && sent < 3; t++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rand_data();
            tick(o);
            if (o.fi) sent++;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick(o);
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 8; t++) begin
            tick(o);
            n_cmp++;
            if (o.ov !== 1'b0) begin n_bad++; $display("FAIL mreset_no_valid: got out_valid %0b at cycle %0d, expected 0", o.ov, t); end
        end
        bus.in_data = rand_data();
        sent = 0;
        for (int t = 0; t < 20 && (sent < 1 || exp_q.size() > 0); t++) begin
            bus.in_valid = (sent < 1);
            tick(o);
            if (o.fi) sent++;
            if (o.fo) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL mreset_result: got %0d, no result expected", o.res); end
                else begin
                    e = exp_q.pop_front();
                    if (o.res !== e.res || o.sat !== e.sat) begin
                        n_bad++; $display("FAIL mreset_result: got %0d sat %0b, expected %0d sat %0b", o.res, o.sat, e.res, e.sat);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (sent != 1 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL mreset_drain: sent %0d, %0d outstanding, expected 1 sent and 0 outstanding", sent, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.w_we      = 1'b0;
        bus.w_idx     = '0;
        bus.w_data    = '0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_accumulate();
        test_weight_timing();
        test_backpressure();
        test_saturate();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
